// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port synchronous-read data RAM (CPU vs DBG).
// Define DMEM_ARB_CPU_PRIORITY_EN for fixed CPU priority instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;      // 1 = DBG owns the current transaction
  logic                cmd_wr_q, cmd_wr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_wr_q, mem_wr_d;
  logic                cpu_gnt_q, cpu_gnt_d, dbg_gnt_q, dbg_gnt_d;
  logic                cpu_rvalid_q, cpu_rvalid_d, dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
  logic                busy_q, busy_d;
  logic                win_dbg;

`ifdef DMEM_ARB_CPU_PRIORITY_EN
  assign win_dbg = dbg_req & ~cpu_req;
`else
  logic last_owner_q, last_owner_d;
  // On a tie DBG wins only if the CPU had the previous grant.
  assign win_dbg = dbg_req & (~cpu_req | ~last_owner_q);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cnt_q        <= 3'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      dbg_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      busy_q       <= 1'b0;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cmd_wr_q     <= cmd_wr_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dbg_gnt_q    <= dbg_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      busy_q       <= busy_d;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cmd_wr_d    = cmd_wr_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          state_d     = ACCESS;
          owner_d     = win_dbg;
          cmd_wr_d    = win_dbg ? dbg_wr    : cpu_wr;
          mem_addr_d  = win_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_d = win_dbg ? dbg_wdata : cpu_wdata;
`ifndef DMEM_ARB_CPU_PRIORITY_EN
          last_owner_d = win_dbg;
`endif
        end
      end
      ACCESS: begin
        if (cmd_wr_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'(RD_LAT);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
          if (owner_q) dbg_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    mem_wr_d     = (state_d == ACCESS) & cmd_wr_d;
    cpu_gnt_d    = (state_d == ACCESS) & ~owner_d;
    dbg_gnt_d    = (state_d == ACCESS) &  owner_d;
    cpu_rvalid_d = (state_d == RESP)   & ~owner_d;
    dbg_rvalid_d = (state_d == RESP)   &  owner_d;
    busy_d       = (state_d != IDLE);
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_gnt    = dbg_gnt_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wr     = mem_wr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter for the single-port data RAM, which is 256 words of 16 bits with synchronous read.
- It shares the RAM between the processor controller's load/store path (CPU port) and a debug/loader port (DBG port), used for program preload and display readback.
- Each request is sequenced through a fixed access/wait/response state machine.
- It drives the RAM address, write-data and write-enable pins in place of the controller.

Parameters:
- ADDR_W, 8: RAM address width.
- DATA_W, 16: RAM data width.
- RD_LAT, 1: RAM read latency in cycles, from the address-sampling edge to valid mem_rdata. Legal range 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; held until cpu_gnt.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle accept pulse.
- cpu_rvalid  out  1  one-cycle read-data-valid pulse.
- cpu_rdata  out  DATA_W  read data; held until the next CPU read completes.
- dbg_req, dbg_wr, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the CPU port, for DBG.
- mem_addr  out  ADDR_W  RAM address.
- mem_wr  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; last_owner = DBG, so the CPU wins the first tie.
  - All outputs = 0, including mem_addr, mem_wdata and both rdata registers.
  - Reset takes effect immediately mid-operation: mem_wr drops with no clock edge, and no gnt/rvalid is issued for the aborted transaction.
- All outputs are registered.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - mem_wr = 0.
  - If any request is high at the edge: choose the winner, capture its wr/addr/wdata into the command registers, and go to ACCESS.
  - Round-robin: with one requester, it wins. With both requesting, the port that is not last_owner wins. last_owner updates on entry to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr = captured addr; mem_wdata = captured wdata; mem_wr = captured wr.
  - The winner's gnt = 1; the other gnt = 0.
  - Write: next state IDLE.
  - Read: load the wait counter with RD_LAT, go to WAIT.
- WAIT (RD_LAT cycles):
  - mem_addr is held, mem_wr = 0, counter decrements each cycle.
  - On the edge ending the last WAIT cycle, mem_rdata is captured into the winner's rdata register; next state RESP.
- RESP (1 cycle): the winner's rvalid = 1; next state IDLE.
- Timing, with a request first seen in IDLE during cycle t:
  - gnt in cycle t+1.
  - Write lands at the t+1 edge.
  - Read: rvalid in cycle t+2+RD_LAT.
- Throughput and idle-cycle rules:
  - There is one IDLE cycle minimum between transactions: write every 2 cycles; read every 3+RD_LAT cycles.
- Handshake rules:
  - Requesters keep req, wr, addr and wdata stable until they sample gnt.
  - A req still high in the IDLE cycle after gnt is a new request.
  - A request that drops before gnt is lost without error; the arbiter never grants a request that is low at the IDLE edge.
- Isolation:
  - The non-winning port sees no gnt/rvalid and its rdata is unchanged.
  - Requests arriving in ACCESS/WAIT/RESP wait for IDLE.
- Boundary conditions:
  - Addresses 0x00 and 0xFF pass unmodified.
  - No address arithmetic, and no wrap behaviour.

Optional Feature:
- Macro DMEM_ARB_CPU_PRIORITY_EN.
- Defined: fixed priority. The CPU wins every simultaneous request; DBG is granted only in an IDLE cycle with cpu_req low. last_owner is unused.
- Undefined (default): round-robin as above.

Test Plan:
- Reset pulse low for 2 cycles mid-stream -> all outputs 0, busy 0; after release, the first simultaneous request goes to the CPU.
- CPU write addr 0x10, data 0x1234 -> cpu_gnt for exactly one cycle; in that cycle mem_wr=1, mem_addr=0x10, mem_wdata=0x1234; no rvalid; dbg_gnt stays 0.
- CPU read addr 0x10, RAM model holding 0x1234, RD_LAT=1 -> cpu_gnt at t+1, cpu_rvalid at t+3 with cpu_rdata=0x1234; dbg_rdata unchanged. Repeat at RD_LAT=3 -> cpu_rvalid at t+5.
- Both ports hold read requests continuously (CPU addr 0x01, DBG addr 0xFF) for 6 grants -> grant order CPU,DBG,CPU,DBG,CPU,DBG with correct data per port. With DMEM_ARB_CPU_PRIORITY_EN defined -> all CPU, and DBG is served only after cpu_req drops.
- DBG write 0xFF=0xBEEF followed by a CPU read of 0xFF -> CPU gets 0xBEEF; busy is high from ACCESS through RESP and low in IDLE.
- Reset asserted during WAIT of a DBG read -> mem_wr 0 immediately, no dbg_rvalid after release, dbg_rdata = 0, state IDLE.
